// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and default sizes for the APB master bridge
// Contents:
//   apb_state_e    : transfer phase (IDLE, SETUP, ACCESS)
//   APB_DATA_SIZE  : default APB data width in bits
//   APB_ADDR_SIZE  : default APB address width in bits
//   APB_TIMEOUT    : default wait-state limit (0 disables the abort)
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_DATA_SIZE = 32;
    localparam int APB_ADDR_SIZE = 6;
    localparam int APB_TIMEOUT   = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - saturating ACCESS wait-state counter with expiry flag
// Ports:
//   clk_i     : clock, rising edge
//   rst_i     : synchronous active-high reset
//   clear_i   : zero the count (asserted in SETUP, before ACCESS begins)
//   enable_i  : count one wait state (ACCESS with PREADY low)
//   expired_o : current ACCESS cycle is the last one allowed before abort
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] SAT_VALUE = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != SAT_VALUE)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With TIMEOUT=0 the counter parks at zero and never reports expiry.
    assign expired_o = (TIMEOUT != 0) && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding command/response to APB requester
// Ports:
//   PCLK, PRESET         : clock and synchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake; cmd_write, cmd_addr, cmd_wdata, cmd_strobe
//   rsp_valid            : one-cycle completion pulse; rsp_rdata, rsp_slverr, rsp_timeout held
//   PADDR..PSTROBE       : APB request outputs (all registered)
//   PRDATA, PREADY, PSLVERR : APB completion inputs
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int DATA_SIZE = APB_DATA_SIZE,
    parameter int ADDR_SIZE = APB_ADDR_SIZE,
    parameter int TIMEOUT   = APB_TIMEOUT
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [ADDR_SIZE-1:0]   cmd_addr,
    input  logic [DATA_SIZE-1:0]   cmd_wdata,
    input  logic [DATA_SIZE/8-1:0] cmd_strobe,
    output logic                   rsp_valid,
    output logic [DATA_SIZE-1:0]   rsp_rdata,
    output logic                   rsp_slverr,
    output logic                   rsp_timeout,
    output logic [ADDR_SIZE-1:0]   PADDR,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [DATA_SIZE-1:0]   PWDATA,
    output logic [DATA_SIZE/8-1:0] PSTROBE,
    input  logic [DATA_SIZE-1:0]   PRDATA,
    input  logic                   PREADY,
    input  logic                   PSLVERR
);

    localparam int STRB_SIZE = DATA_SIZE / 8;

    apb_state_e             state_q, state_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [ADDR_SIZE-1:0]   paddr_q, paddr_d;
    logic [DATA_SIZE-1:0]   pwdata_q, pwdata_d;
    logic [STRB_SIZE-1:0]   pstrobe_q, pstrobe_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_slverr_q, rsp_slverr_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic                   timer_expired;

    assign cmd_ready = (state_q == IDLE) && !PRESET;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .clear_i   (state_q == SETUP),
        .enable_i  ((state_q == ACCESS) && !PREADY),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrobe_d     = pstrobe_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    // Reads drive zero data/strobes so the bus never carries stale write data.
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    pstrobe_d = cmd_write ? cmd_strobe : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = PSLVERR;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_timeout_d = 1'b0;
                end else if (timer_expired) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrobe_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrobe_q     <= pstrobe_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PSTROBE     = pstrobe_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge with a memory slave
module tb_apb_master_bridge;

    localparam int TMO = 16;

    logic        PCLK;
    logic        PRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strobe;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic [5:0]  PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTROBE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        logic        tmo;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem[64];
    logic [31:0] ref_mem[64];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          wait_n = 0;
    bit          hang = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    apb_master_bridge #(
        .DATA_SIZE (32),
        .ADDR_SIZE (6),
        .TIMEOUT   (TMO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strobe  (cmd_strobe),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_slverr  (rsp_slverr),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PSTROBE     (PSTROBE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Memory slave: wait_n low-PREADY cycles per access, or never ready while hang is set.
    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (PRESET) begin
            for (int a = 0; a < 64; a++) mem[a] <= '0;
            acc_cnt <= 0;
        end else begin
            if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
            else acc_cnt <= 0;
            if (PSEL && PENABLE && PREADY && PWRITE && PADDR != 6'h3F)
                for (int b = 0; b < 4; b++)
                    if (PSTROBE[b]) mem[PADDR][8*b +: 8] <= PWDATA[8*b +: 8];
        end
    end

    assign PRDATA  = mem[PADDR];
    assign PREADY  = !hang && (acc_cnt >= wait_n);
    assign PSLVERR = PSEL && PENABLE && (PADDR == 6'h3F);

    task automatic clear_ref();
        for (int a = 0; a < 64; a++) ref_mem[a] = '0;
    endtask

    // Drive one command, wait for acceptance, and queue the response the model predicts.
    task automatic issue(input logic w, input logic [5:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit hold);
        int guard;
        cmd_valid  = 1'b1;
        cmd_write  = w;
        cmd_addr   = a;
        cmd_wdata  = d;
        cmd_strobe = s;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge PCLK);
            guard++;
        end
        n_checks++;
        if (!cmd_ready) begin
            $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            n_pass++;
            if (hang) begin
                sb.push_back('{rdata: 32'h0, slverr: 1'b1, tmo: 1'b1, due: cyc + 2 + TMO});
            end else begin
                sb.push_back('{rdata: w ? 32'h0 : ref_mem[a], slverr: (a == 6'h3F),
                               tmo: 1'b0, due: cyc + 3 + wait_n});
                if (w && a != 6'h3F)
                    for (int b = 0; b < 4; b++)
                        if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            end
            @(posedge PCLK);
            #1;
            if (!hold) cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        cmd_strobe = '0;
        clear_ref();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTROBE, rsp_valid, rsp_rdata,
             rsp_slverr, rsp_timeout} !== '0)
            $display("FAIL reset_outputs: psel=%b pen=%b paddr=%h pwdata=%h rsp_valid=%b required all 0",
                     PSEL, PENABLE, PADDR, PWDATA, rsp_valid);
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready);
        else n_pass++;
        PRESET = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready: got %b required 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_write();
        exp_t e;
        issue(1'b1, 6'h05, 32'h5555_5555, 4'hF, 1'b0);
        @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTROBE, cmd_ready} !==
            {1'b1, 1'b0, 1'b1, 6'h05, 32'h5555_5555, 4'hF, 1'b0})
            $display("FAIL write_setup: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h pstrobe=%h ready=%b required 1 0 1 05 55555555 f 0",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTROBE, cmd_ready);
        else n_pass++;
        @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE, cmd_ready} !== 3'b110)
            $display("FAIL write_access: psel=%b pen=%b ready=%b required 1 1 0", PSEL, PENABLE, cmd_ready);
        else n_pass++;
        @(negedge PCLK);
        n_checks++;
        if (!rsp_valid || sb.size() == 0)
            $display("FAIL write_rsp: rsp_valid=%b queued=%0d required a response", rsp_valid, sb.size());
        else begin
            e = sb.pop_front();
            if ({rsp_rdata, rsp_slverr, rsp_timeout, PSEL, PENABLE} !== {e.rdata, e.slverr, e.tmo, 2'b00} || cyc !== e.due)
                $display("FAIL write_rsp: rdata=%h err=%b tmo=%b psel=%b cyc=%0d required %h %b %b 0 cyc=%0d",
                         rsp_rdata, rsp_slverr, rsp_timeout, PSEL, cyc, e.rdata, e.slverr, e.tmo, e.due);
            else n_pass++;
        end
    endtask

    task automatic test_read();
        exp_t e;
        issue(1'b0, 6'h05, 32'hDEAD_BEEF, 4'hF, 1'b0);
        @(negedge PCLK);
        n_checks++;
        if ({PSEL, PWRITE, PWDATA, PSTROBE} !== {1'b1, 1'b0, 32'h0, 4'h0})
            $display("FAIL read_setup: psel=%b pwrite=%b pwdata=%h pstrobe=%h required 1 0 0 0",
                     PSEL, PWRITE, PWDATA, PSTROBE);
        else n_pass++;
        repeat (2) @(negedge PCLK);
        n_checks++;
        if (!rsp_valid || sb.size() == 0)
            $display("FAIL read_rsp: rsp_valid=%b queued=%0d required a response", rsp_valid, sb.size());
        else begin
            e = sb.pop_front();
            if ({rsp_rdata, rsp_slverr, rsp_timeout} !== {32'h5555_5555, 2'b00} ||
                {rsp_rdata, rsp_slverr, rsp_timeout} !== {e.rdata, e.slverr, e.tmo} || cyc !== e.due)
                $display("FAIL read_rsp: rdata=%h err=%b tmo=%b cyc=%0d required 55555555 0 0 cyc=%0d",
                         rsp_rdata, rsp_slverr, rsp_timeout, cyc, e.due);
            else n_pass++;
        end
    endtask

    task automatic test_wait_states();
        exp_t e;
        wait_n = 4;
        issue(1'b1, 6'h0A, 32'hA5A5_1234, 4'b0011, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge PCLK);
            n_checks++;
            if ({PSEL, PADDR, PWDATA, rsp_valid} !== {1'b1, 6'h0A, 32'hA5A5_1234, 1'b0})
                $display("FAIL wait_stable[%0d]: psel=%b paddr=%h pwdata=%h rsp_valid=%b required 1 0a a5a51234 0",
                         k, PSEL, PADDR, PWDATA, rsp_valid);
            else n_pass++;
        end
        @(negedge PCLK);
        n_checks++;
        if (!rsp_valid || sb.size() == 0)
            $display("FAIL wait_rsp: rsp_valid=%b queued=%0d required a response 7 cycles after accept",
                     rsp_valid, sb.size());
        else begin
            e = sb.pop_front();
            if ({rsp_rdata, rsp_slverr, rsp_timeout} !== {e.rdata, e.slverr, e.tmo} || cyc !== e.due)
                $display("FAIL wait_rsp: rdata=%h err=%b tmo=%b cyc=%0d required %h %b %b cyc=%0d",
                         rsp_rdata, rsp_slverr, rsp_timeout, cyc, e.rdata, e.slverr, e.tmo, e.due);
            else n_pass++;
        end
        wait_n = 0;
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   got;
        hang = 1'b1;
        issue(1'b0, 6'h07, 32'h0, 4'h0, 1'b0);
        got = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                got = 1;
                break;
            end
        end
        n_checks++;
        if (!got || sb.size() == 0)
            $display("FAIL timeout_rsp: rsp_valid=%b queued=%0d required an abort response", rsp_valid, sb.size());
        else begin
            e = sb.pop_front();
            if ({rsp_rdata, rsp_slverr, rsp_timeout, PSEL, PENABLE} !== {32'h0, 1'b1, 1'b1, 2'b00} || cyc !== e.due)
                $display("FAIL timeout_rsp: rdata=%h err=%b tmo=%b psel=%b cyc=%0d required 0 1 1 0 cyc=%0d",
                         rsp_rdata, rsp_slverr, rsp_timeout, PSEL, cyc, e.due);
            else n_pass++;
        end
        hang = 1'b0;
        issue(1'b0, 6'h0A, 32'h0, 4'h0, 1'b0);
        repeat (3) @(negedge PCLK);
        n_checks++;
        if (!rsp_valid || sb.size() == 0)
            $display("FAIL after_timeout_rsp: rsp_valid=%b queued=%0d required a response", rsp_valid, sb.size());
        else begin
            e = sb.pop_front();
            if ({rsp_rdata, rsp_slverr, rsp_timeout} !== {32'h0000_1234, 2'b00} ||
                {rsp_rdata, rsp_slverr, rsp_timeout} !== {e.rdata, e.slverr, e.tmo} || cyc !== e.due)
                $display("FAIL after_timeout_rsp: rdata=%h err=%b tmo=%b cyc=%0d required 00001234 0 0 cyc=%0d",
                         rsp_rdata, rsp_slverr, rsp_timeout, cyc, e.due);
            else n_pass++;
        end
    endtask

    task automatic test_slverr();
        exp_t e;
        issue(1'b1, 6'h3F, 32'h1111_2222, 4'hF, 1'b0);
        repeat (3) @(negedge PCLK);
        n_checks++;
        if (!rsp_valid || sb.size() == 0)
            $display("FAIL slverr_rsp: rsp_valid=%b queued=%0d required a response", rsp_valid, sb.size());
        else begin
            e = sb.pop_front();
            if ({rsp_rdata, rsp_slverr, rsp_timeout} !== {32'h0, 1'b1, 1'b0} ||
                {rsp_rdata, rsp_slverr, rsp_timeout} !== {e.rdata, e.slverr, e.tmo})
                $display("FAIL slverr_rsp: rdata=%h err=%b tmo=%b required 0 1 0",
                         rsp_rdata, rsp_slverr, rsp_timeout);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int rsp_seen;
        hang = 1'b1;
        issue(1'b1, 6'h10, 32'hCAFE_F00D, 4'hF, 1'b0);
        repeat (3) @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE} !== 2'b11)
            $display("FAIL mid_in_access: psel=%b pen=%b required 1 1", PSEL, PENABLE);
        else n_pass++;
        PRESET = 1'b1;
        @(negedge PCLK);
        n_checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTROBE, rsp_valid, rsp_rdata,
             rsp_slverr, rsp_timeout, cmd_ready} !== '0)
            $display("FAIL mid_reset_outputs: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h rsp_valid=%b ready=%b required all 0",
                     PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, cmd_ready);
        else n_pass++;
        sb.delete();
        clear_ref();
        hang = 1'b0;
        PRESET = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL mid_cmd_ready: got %b required 1", cmd_ready);
        else n_pass++;
        rsp_seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge PCLK);
            if (rsp_valid) rsp_seen++;
        end
        n_checks++;
        if (rsp_seen !== 0) $display("FAIL mid_no_rsp: saw %0d rsp_valid pulses required 0", rsp_seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   prev_setup;
        int   rsp_count;
        rsp_count = 0;
        prev_setup = 0;
        for (int i = 0; i < 50; i++) begin
            if (i > 0) begin
                @(negedge PCLK);
                n_checks++;
                if (!rsp_valid || sb.size() == 0)
                    $display("FAIL b2b_rsp[%0d]: rsp_valid=%b queued=%0d required a response", i - 1, rsp_valid, sb.size());
                else begin
                    e = sb.pop_front();
                    rsp_count++;
                    if ({rsp_rdata, rsp_slverr, rsp_timeout} !== {e.rdata, e.slverr, e.tmo} || cyc !== e.due)
                        $display("FAIL b2b_rsp[%0d]: rdata=%h err=%b cyc=%0d required %h %b cyc=%0d",
                                 i - 1, rsp_rdata, rsp_slverr, cyc, e.rdata, e.slverr, e.due);
                    else n_pass++;
                end
            end
            issue(1'b1, 6'(i), $urandom, 4'(4 - i), 1'b1);
            @(negedge PCLK);
            n_checks++;
            if ({PSEL, PENABLE, cmd_ready, PADDR, PSTROBE} !== {3'b100, 6'(i), 4'(4 - i)} ||
                (i > 0 && cyc - prev_setup != 3))
                $display("FAIL b2b_setup[%0d]: psel=%b pen=%b ready=%b paddr=%h pstrobe=%h period=%0d required 1 0 0 %h %h period 3",
                         i, PSEL, PENABLE, cmd_ready, PADDR, PSTROBE, cyc - prev_setup, 6'(i), 4'(4 - i));
            else n_pass++;
            prev_setup = cyc;
            @(negedge PCLK);
            n_checks++;
            if ({PSEL, PENABLE, cmd_ready} !== 3'b110)
                $display("FAIL b2b_access[%0d]: psel=%b pen=%b ready=%b required 1 1 0", i, PSEL, PENABLE, cmd_ready);
            else n_pass++;
        end
        cmd_valid = 1'b0;
        @(negedge PCLK);
        if (rsp_valid && sb.size() != 0) begin
            e = sb.pop_front();
            rsp_count++;
        end
        n_checks++;
        if (rsp_count !== 50 || sb.size() !== 0)
            $display("FAIL b2b_count: responses=%0d left=%0d required 50 0", rsp_count, sb.size());
        else n_pass++;
        // Read back the addresses whose strobes varied (4, 3, 2, 1, 0, f).
        for (int j = 0; j < 6; j++) begin
            issue(1'b0, 6'(j), 32'h0, 4'h0, 1'b0);
            repeat (3) @(negedge PCLK);
            n_checks++;
            if (!rsp_valid || sb.size() == 0)
                $display("FAIL readback_rsp[%0d]: rsp_valid=%b queued=%0d required a response", j, rsp_valid, sb.size());
            else begin
                e = sb.pop_front();
                if ({rsp_rdata, rsp_slverr, rsp_timeout} !== {e.rdata, e.slverr, e.tmo})
                    $display("FAIL readback_rsp[%0d]: rdata=%h required %h", j, rsp_rdata, e.rdata);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wait_states();
        test_timeout();
        test_slverr();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
